// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch front end: data width, the NOP encoding
// used as the idle instruction, the fetch FSM states and the PC select codes.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    BOOT = 3'd0,
    REQ  = 3'd1,
    RESP = 3'd2,
    HOLD = 3'd3,
    HALT = 3'd4
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_TGT  = 2'd2
  } pc_sel_t;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC select: hold, sequential +4, or redirect target.
// Build option PC_MISALIGN_CHECK_EN: when undefined, the target's low two bits
// are forced to zero here; when defined, the target passes through unchanged
// and the fetch unit refuses misaligned redirects itself.
module pc_next_sel
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] branch_target,
  input  pc_sel_t         sel,
  output logic [XLEN-1:0] pc_next
);

  logic [XLEN-1:0] target_aligned;

`ifdef PC_MISALIGN_CHECK_EN
  assign target_aligned = branch_target;
`else
  assign target_aligned = branch_target & ~XLEN'(3);
`endif

  // Pick the next PC; +4 wraps naturally at the top of the address space.
  always_comb begin
    pc_next = pc;
    case (sel)
      PC_INC:  pc_next = pc + XLEN'(4);
      PC_TGT:  pc_next = target_aligned;
      default: pc_next = pc;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction fetch front end.
// Memory handshake: imem_req is held until imem_gnt; the request is accepted
// in the cycle req & gnt are both high, and exactly one imem_rvalid follows
// in a later cycle. Decode side: instr_valid holds instr/instr_pc until a
// cycle with !stall consumes them. imem_req/imem_addr come from registers only.
// Build option PC_MISALIGN_CHECK_EN enables the HALT-on-misaligned-redirect path.
module pc_fetch_unit
  import riscv_pkg::*;
#(
  parameter int               XLEN         = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PCSrc,
  input  logic [XLEN-1:0]   branch_target,
  input  logic              stall,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [XLEN-1:0]   instr_pc,
  output logic              misaligned,
  output fetch_state_t      dbg_state
);

  fetch_state_t    state, state_n;
  logic [XLEN-1:0] pc, pc_next;
  pc_sel_t         pc_sel;
  logic            kill, kill_n;
  logic            valid_n;
  logic            capture;

  pc_next_sel #(.XLEN(XLEN)) u_pc_next_sel (
    .pc            (pc),
    .branch_target (branch_target),
    .sel           (pc_sel),
    .pc_next       (pc_next)
  );

  assign imem_req  = (state == REQ);
  assign imem_addr = pc;
  assign dbg_state = state;

`ifdef PC_MISALIGN_CHECK_EN
  logic bad_target;
  logic mis_n;
  assign bad_target = PCSrc && (branch_target[1:0] != 2'b00);
`endif

  // Next-state, PC select and output-register control; redirect wins over
  // stall and consumption in every state.
  always_comb begin
    state_n = state;
    pc_sel  = PC_HOLD;
    kill_n  = kill;
    valid_n = instr_valid;
    capture = 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
    mis_n   = misaligned;
`endif
    case (state)
      BOOT: begin
        state_n = REQ;
        if (PCSrc) pc_sel = PC_TGT;
      end
      REQ: begin
        if (PCSrc) pc_sel = PC_TGT;
        if (imem_gnt) begin
          state_n = RESP;
          kill_n  = PCSrc;  // accepted request is for the old address
        end
      end
      RESP: begin
        if (PCSrc) begin
          pc_sel = PC_TGT;
          if (imem_rvalid) begin
            state_n = REQ;
            kill_n  = 1'b0;
          end else begin
            kill_n  = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (kill) begin
            state_n = REQ;
            kill_n  = 1'b0;
          end else begin
            capture = 1'b1;
            valid_n = 1'b1;
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        if (PCSrc) begin
          pc_sel  = PC_TGT;
          valid_n = 1'b0;
          state_n = REQ;
        end else if (!stall) begin
          pc_sel  = PC_INC;
          valid_n = 1'b0;
          state_n = REQ;
        end
      end
`ifdef PC_MISALIGN_CHECK_EN
      HALT: begin
        valid_n = 1'b0;
      end
`endif
      default: begin
        state_n = BOOT;
      end
    endcase
`ifdef PC_MISALIGN_CHECK_EN
    // A misaligned redirect parks the unit until reset; any response is dropped.
    if (state != HALT && bad_target) begin
      state_n = HALT;
      pc_sel  = PC_HOLD;
      valid_n = 1'b0;
      capture = 1'b0;
      kill_n  = 1'b0;
      mis_n   = 1'b1;
    end
`endif
  end

  // State, PC, kill flag and the decode-facing output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_VECTOR;
      kill        <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= NOP_INSTR;
      instr_pc    <= RESET_VECTOR;
    end else begin
      state       <= state_n;
      pc          <= pc_next;
      kill        <= kill_n;
      instr_valid <= valid_n;
      if (capture) begin
        instr    <= imem_rdata;
        instr_pc <= pc;
      end
    end
  end

`ifdef PC_MISALIGN_CHECK_EN
  // Sticky misaligned flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misaligned <= 1'b0;
    else     misaligned <= mis_n;
  end
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a behavioural instruction memory that
// grants immediately and answers after a programmable number of extra cycles.
module tb_pc_fetch_unit;
  import riscv_pkg::*;

  localparam int W = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            PCSrc;
  logic [W-1:0]    branch_target;
  logic            stall;
  logic            imem_req;
  logic [W-1:0]    imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            instr_valid;
  logic [31:0]     instr;
  logic [W-1:0]    instr_pc;
  logic            misaligned;
  fetch_state_t    dbg_state;

  int errors = 0;
  int checks = 0;
  int mem_lat = 0;
  logic [W-1:0] exp_q[$];

  // Clock
  always #5 clk = ~clk;

  pc_fetch_unit #(.XLEN(W), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .PCSrc         (PCSrc),
    .branch_target (branch_target),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .misaligned    (misaligned),
    .dbg_state     (dbg_state)
  );

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h0) return 32'h00A0_0093;
    return {a[15:0], 16'h0013};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_state(input fetch_state_t s, input string tag);
    int n = 0;
    while (dbg_state !== s && n < 30) begin
      tick();
      n++;
    end
    check_eq(tag, dbg_state, s);
  endtask

  // Wait for the next presented instruction and compare with the queue head.
  task automatic wait_fetch(input string tag);
    int n = 0;
    logic [W-1:0] e;
    while (instr_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check_eq({tag, "_valid"}, instr_valid, 1'b1);
    e = exp_q.pop_front();
    check_eq({tag, "_pc"}, instr_pc, e);
    check_eq({tag, "_instr"}, instr, mem_data(e));
  endtask

  // Memory model: one outstanding request, grant on sight, data mem_lat later.
  initial begin : responder
    logic pend;
    int cnt;
    logic [31:0] paddr;
    pend = 1'b0;
    cnt = 0;
    paddr = '0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata = mem_data(paddr);
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end else if (imem_req === 1'b1) begin
        imem_gnt = 1'b1;
        pend = 1'b1;
        cnt = mem_lat;
        paddr = imem_addr;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    rst = 1'b1;
    PCSrc = 1'b0;
    branch_target = '0;
    stall = 1'b1;
    tick();

    // Reset values
    check_eq("rst_req", imem_req, 1'b0);
    check_eq("rst_addr", imem_addr, 32'h0);
    check_eq("rst_valid", instr_valid, 1'b0);
    check_eq("rst_instr", instr, 32'h0000_0013);
    check_eq("rst_instr_pc", instr_pc, 32'h0);
    check_eq("rst_misaligned", misaligned, 1'b0);
    check_eq("rst_state", dbg_state, BOOT);

    // First fetch at the reset vector
    rst = 1'b0;
    tick();
    check_eq("boot_req", imem_req, 1'b1);
    check_eq("boot_addr", imem_addr, 32'h0);
    exp_q.push_back(32'h0);
    wait_fetch("t1");

    // Stall holds the output register and blocks new requests
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("stall_pc", instr_pc, 32'h0);
      check_eq("stall_instr", instr, 32'h00A0_0093);
      check_eq("stall_req", imem_req, 1'b0);
      check_eq("stall_valid", instr_valid, 1'b1);
    end
    mem_lat = 3;
    stall = 1'b0;
    tick();
    stall = 1'b1;
    check_eq("seq_req", imem_req, 1'b1);
    check_eq("seq_addr", imem_addr, 32'h4);
    check_eq("seq_valid", instr_valid, 1'b0);

    // Redirect while waiting for a slow response
    wait_state(RESP, "t3_resp");
    PCSrc = 1'b1;
    branch_target = 32'h100;
    mem_lat = 0;
    tick();
    PCSrc = 1'b0;
    check_eq("t3_addr", imem_addr, 32'h100);
    check_eq("t3_req", imem_req, 1'b0);
    check_eq("t3_state", dbg_state, RESP);
    exp_q.push_back(32'h100);
    wait_fetch("t3");

    // Redirect from HOLD to 0x8, then redirect again in the grant cycle
    PCSrc = 1'b1;
    branch_target = 32'h8;
    tick();
    check_eq("t4_addr8", imem_addr, 32'h8);
    check_eq("t4_valid", instr_valid, 1'b0);
    check_eq("t4_req", imem_req, 1'b1);
    branch_target = 32'h40;
    tick();
    PCSrc = 1'b0;
    check_eq("t4_state", dbg_state, RESP);
    check_eq("t4_addr40", imem_addr, 32'h40);
    exp_q.push_back(32'h40);
    wait_fetch("t4");

    // Sequential wrap at the top of the address space
    PCSrc = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    tick();
    PCSrc = 1'b0;
    exp_q.push_back(32'hFFFF_FFFC);
    wait_fetch("t5_top");
    stall = 1'b0;
    tick();
    stall = 1'b1;
    check_eq("t5_wrap_addr", imem_addr, 32'h0);
    check_eq("t5_wrap_req", imem_req, 1'b1);
    exp_q.push_back(32'h0);
    wait_fetch("t5_wrap");

    // Misaligned redirect
    PCSrc = 1'b1;
    branch_target = 32'h102;
    tick();
    PCSrc = 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
    check_eq("t6_state", dbg_state, HALT);
    check_eq("t6_misaligned", misaligned, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check_eq("t6_req", imem_req, 1'b0);
      check_eq("t6_valid", instr_valid, 1'b0);
      check_eq("t6_sticky", misaligned, 1'b1);
      tick();
    end
    rst = 1'b1;
    #1;
    check_eq("t6_rst_misaligned", misaligned, 1'b0);
    check_eq("t6_rst_state", dbg_state, BOOT);
    tick();
    rst = 1'b0;
    tick();
`else
    check_eq("t6_addr", imem_addr, 32'h100);
    check_eq("t6_misaligned", misaligned, 1'b0);
    exp_q.push_back(32'h100);
    wait_fetch("t6");
    rst = 1'b1;
    tick();
    rst = 1'b0;
`endif

    // Reset in the middle of an outstanding fetch; the late response is ignored
    mem_lat = 2;
    wait_state(RESP, "t7_resp");
    rst = 1'b1;
    #1;
    check_eq("t7_state", dbg_state, BOOT);
    check_eq("t7_req", imem_req, 1'b0);
    check_eq("t7_valid", instr_valid, 1'b0);
    tick();
    rst = 1'b0;
    mem_lat = 0;
    exp_q.push_back(32'h0);
    wait_fetch("t7");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
